// File: rtl/ball_bounce_engine.sv
// Bouncing-ball object: per-frame position update with wall bounce,
// launch/pause control and beam-relative ball graphics.
module ball_bounce_engine #(
   parameter int WIDTH      = 9,
   parameter int BALL_SIZE  = 4,
   parameter int X_MIN      = 0,
   parameter int X_MAX      = 256,
   parameter int Y_MIN      = 0,
   parameter int Y_MAX      = 240,
   parameter int INIT_X     = 128,
   parameter int INIT_Y     = 128,
   parameter int INIT_DX    = -2,
   parameter int INIT_DY    = 2,
   parameter int SPEED_BITS = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  vsync,
   input  logic [WIDTH-1:0]      hpos,
   input  logic [WIDTH-1:0]      vpos,
   input  logic                  launch,
   input  logic                  pause,
   input  logic [SPEED_BITS-1:0] dx_mag,
   input  logic [SPEED_BITS-1:0] dy_mag,
   output logic [WIDTH-1:0]      ball_x,
   output logic [WIDTH-1:0]      ball_y,
   output logic                  ball_hgfx,
   output logic                  ball_vgfx,
   output logic                  ball_gfx,
   output logic                  hit_x,
   output logic                  hit_y,
   output logic                  moving
);

   localparam int CW = WIDTH + 2;

   localparam logic signed [CW-1:0] C_XMIN = CW'(X_MIN);
   localparam logic signed [CW-1:0] C_YMIN = CW'(Y_MIN);
   localparam logic signed [CW-1:0] C_XLIM = CW'(X_MAX - BALL_SIZE);
   localparam logic signed [CW-1:0] C_YLIM = CW'(Y_MAX - BALL_SIZE);
   localparam logic signed [CW-1:0] C_IDX  = CW'(INIT_DX);
   localparam logic signed [CW-1:0] C_IDY  = CW'(INIT_DY);
   localparam logic signed [CW-1:0] C_ADX  = CW'((INIT_DX < 0) ? -INIT_DX : INIT_DX);
   localparam logic signed [CW-1:0] C_ADY  = CW'((INIT_DY < 0) ? -INIT_DY : INIT_DY);
   localparam logic [WIDTH-1:0]     C_BS   = WIDTH'(BALL_SIZE);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_RUN    = 2'd1,
      S_PAUSED = 2'd2
   } state_t;

   state_t r_state;
   state_t w_state_next;

   logic                 r_vsync_q;
   logic [WIDTH-1:0]     r_ball_x;
   logic [WIDTH-1:0]     r_ball_y;
   logic signed [CW-1:0] r_dx;
   logic signed [CW-1:0] r_dy;
   logic                 r_hit_x;
   logic                 r_hit_y;

   logic                 w_tick;
   logic                 w_load;
   logic                 w_step;
   logic signed [CW-1:0] w_nx;
   logic signed [CW-1:0] w_ny;
   logic signed [CW-1:0] w_lmx;
   logic signed [CW-1:0] w_lmy;
   logic [WIDTH-1:0]     w_hdiff;
   logic [WIDTH-1:0]     w_vdiff;

   assign w_tick = vsync & ~r_vsync_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_vsync_q <= 1'b0;
      end else begin
         r_state   <= w_state_next;
         r_vsync_q <= vsync;
      end
   end

   // Pause wins over a coincident frame tick.
   always_comb begin
      w_state_next = r_state;
      w_load       = 1'b0;
      w_step       = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (launch) begin
               w_state_next = S_RUN;
               w_load       = 1'b1;
            end
         end
         S_RUN: begin
            if (pause) begin
               w_state_next = S_PAUSED;
            end else if (w_tick) begin
               w_step = 1'b1;
            end
         end
         S_PAUSED: begin
            if (!pause) begin
               w_state_next = S_RUN;
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   assign w_lmx = (dx_mag == '0) ? C_ADX : CW'(dx_mag);
   assign w_lmy = (dy_mag == '0) ? C_ADY : CW'(dy_mag);

   assign w_nx = $signed({2'b00, r_ball_x}) + r_dx;
   assign w_ny = $signed({2'b00, r_ball_y}) + r_dy;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_ball_x <= WIDTH'(INIT_X);
         r_ball_y <= WIDTH'(INIT_Y);
         r_dx     <= C_IDX;
         r_dy     <= C_IDY;
         r_hit_x  <= 1'b0;
         r_hit_y  <= 1'b0;
      end else begin
         r_hit_x <= 1'b0;
         r_hit_y <= 1'b0;
         if (r_state == S_IDLE) begin
            r_ball_x <= WIDTH'(INIT_X);
            r_ball_y <= WIDTH'(INIT_Y);
         end
         if (w_load) begin
            r_dx <= (INIT_DX < 0) ? -w_lmx : w_lmx;
            r_dy <= (INIT_DY < 0) ? -w_lmy : w_lmy;
         end
         if (w_step) begin
            if (r_dx < 0 && w_nx <= C_XMIN) begin
               r_ball_x <= WIDTH'(X_MIN);
               r_dx     <= -r_dx;
               r_hit_x  <= 1'b1;
            end else if (r_dx > 0 && w_nx >= C_XLIM) begin
               r_ball_x <= WIDTH'(X_MAX - BALL_SIZE);
               r_dx     <= -r_dx;
               r_hit_x  <= 1'b1;
            end else begin
               r_ball_x <= w_nx[WIDTH-1:0];
            end
            if (r_dy < 0 && w_ny <= C_YMIN) begin
               r_ball_y <= WIDTH'(Y_MIN);
               r_dy     <= -r_dy;
               r_hit_y  <= 1'b1;
            end else if (r_dy > 0 && w_ny >= C_YLIM) begin
               r_ball_y <= WIDTH'(Y_MAX - BALL_SIZE);
               r_dy     <= -r_dy;
               r_hit_y  <= 1'b1;
            end else begin
               r_ball_y <= w_ny[WIDTH-1:0];
            end
         end
      end
   end

   // Beam left of / above the ball wraps to a large difference.
   assign w_hdiff   = hpos - r_ball_x;
   assign w_vdiff   = vpos - r_ball_y;
   assign ball_hgfx = w_hdiff < C_BS;
   assign ball_vgfx = w_vdiff < C_BS;
   assign ball_gfx  = ball_hgfx & ball_vgfx;

   assign ball_x = r_ball_x;
   assign ball_y = r_ball_y;
   assign hit_x  = r_hit_x;
   assign hit_y  = r_hit_y;
   assign moving = (r_state == S_RUN);

endmodule

// File: tb/tb_ball_bounce_engine.sv
// Self-checking bench for ball_bounce_engine with a per-frame
// arithmetic reference model of the ball motion.
module tb_ball_bounce_engine;

   logic       clk = 1'b0;
   logic       reset;
   logic       vsync;
   logic [8:0] hpos;
   logic [8:0] vpos;
   logic       launch;
   logic       pause;
   logic [3:0] dx_mag;
   logic [3:0] dy_mag;
   logic [8:0] ball_x;
   logic [8:0] ball_y;
   logic       ball_hgfx;
   logic       ball_vgfx;
   logic       ball_gfx;
   logic       hit_x;
   logic       hit_y;
   logic       moving;

   int checks = 0;
   int errors = 0;

   // reference model state
   int mx, my, mdx, mdy;
   int mhx, mhy;

   ball_bounce_engine dut (
      .clk       (clk),
      .reset     (reset),
      .vsync     (vsync),
      .hpos      (hpos),
      .vpos      (vpos),
      .launch    (launch),
      .pause     (pause),
      .dx_mag    (dx_mag),
      .dy_mag    (dy_mag),
      .ball_x    (ball_x),
      .ball_y    (ball_y),
      .ball_hgfx (ball_hgfx),
      .ball_vgfx (ball_vgfx),
      .ball_gfx  (ball_gfx),
      .hit_x     (hit_x),
      .hit_y     (hit_y),
      .moving    (moving)
   );

   always #5 clk = ~clk;

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1; vsync = 1'b0; launch = 1'b0; pause = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      mx = 128; my = 128; mdx = -2; mdy = 2;
   endtask

   task automatic do_launch(input int dxm, input int dym);
      @(negedge clk);
      dx_mag = 4'(dxm); dy_mag = 4'(dym); launch = 1'b1;
      @(negedge clk);
      launch = 1'b0;
      mdx = -((dxm == 0) ? 2 : dxm);
      mdy =  ((dym == 0) ? 2 : dym);
   endtask

   // one vsync pulse (2 clk high, 4 low); counts hit pulses seen
   task automatic run_frame(output int hxc, output int hyc);
      hxc = 0; hyc = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         vsync = (i < 2);
         @(posedge clk);
         #1;
         hxc += int'(hit_x);
         hyc += int'(hit_y);
      end
   endtask

   // one frame of ideal motion: step, clamp on touching a wall, reflect
   task automatic model_tick();
      int nx, ny;
      nx = mx + mdx; ny = my + mdy;
      mhx = 0; mhy = 0;
      if (mdx < 0 && nx <= 0) begin mx = 0; mdx = -mdx; mhx = 1; end
      else if (mdx > 0 && nx >= 252) begin mx = 252; mdx = -mdx; mhx = 1; end
      else mx = nx;
      if (mdy < 0 && ny <= 0) begin my = 0; mdy = -mdy; mhy = 1; end
      else if (mdy > 0 && ny >= 236) begin my = 236; mdy = -mdy; mhy = 1; end
      else my = ny;
   endtask

   task automatic test_reset();
      int hxc, hyc, tot;
      do_reset();
      #1;
      checks++;
      if (ball_x !== 9'd128 || ball_y !== 9'd128 || moving !== 1'b0 ||
          hit_x !== 1'b0 || hit_y !== 1'b0) begin
         errors++;
         $display("FAIL reset: x=%0d y=%0d mv=%b hx=%b hy=%b want 128 128 0 0 0",
                  ball_x, ball_y, moving, hit_x, hit_y);
      end
      tot = 0;
      for (int f = 0; f < 3; f++) begin
         run_frame(hxc, hyc);
         tot += hxc + hyc;
      end
      checks++;
      if (ball_x !== 9'd128 || ball_y !== 9'd128 || moving !== 1'b0 || tot != 0) begin
         errors++;
         $display("FAIL idle_hold: x=%0d y=%0d mv=%b hits=%0d want 128 128 0 0",
                  ball_x, ball_y, moving, tot);
      end
   endtask

   task automatic test_launch_default();
      int hxc, hyc;
      do_reset();
      do_launch(0, 0);
      #1;
      checks++;
      if (moving !== 1'b1) begin
         errors++;
         $display("FAIL launch_moving: got %b want 1", moving);
      end
      run_frame(hxc, hyc);
      checks++;
      if (ball_x !== 9'd126 || ball_y !== 9'd130) begin
         errors++;
         $display("FAIL tick1: got (%0d,%0d) want (126,130)", ball_x, ball_y);
      end
      for (int f = 1; f < 10; f++) run_frame(hxc, hyc);
      checks++;
      if (ball_x !== 9'd108 || ball_y !== 9'd148) begin
         errors++;
         $display("FAIL tick10: got (%0d,%0d) want (108,148)", ball_x, ball_y);
      end
   endtask

   task automatic test_y_bounce();
      int hxc, hyc, tot;
      do_reset();
      do_launch(0, 2);
      tot = 0;
      for (int f = 1; f <= 53; f++) begin
         run_frame(hxc, hyc);
         tot += hyc;
      end
      run_frame(hxc, hyc);
      checks++;
      if (ball_y !== 9'd236 || hyc != 1 || tot != 0) begin
         errors++;
         $display("FAIL y_bounce54: y=%0d pulses=%0d early=%0d want 236 1 0",
                  ball_y, hyc, tot);
      end
      run_frame(hxc, hyc);
      checks++;
      if (ball_y !== 9'd234 || hyc != 0) begin
         errors++;
         $display("FAIL y_bounce55: y=%0d pulses=%0d want 234 0", ball_y, hyc);
      end
   endtask

   task automatic test_x_bounce();
      int hxc, hyc;
      do_reset();
      do_launch(3, 1);
      for (int f = 1; f <= 42; f++) run_frame(hxc, hyc);
      checks++;
      if (ball_x !== 9'd2 || hxc != 0) begin
         errors++;
         $display("FAIL x_tick42: x=%0d hit=%0d want 2 0", ball_x, hxc);
      end
      run_frame(hxc, hyc);
      checks++;
      if (ball_x !== 9'd0 || hxc != 1) begin
         errors++;
         $display("FAIL x_tick43: x=%0d hit=%0d want 0 1", ball_x, hxc);
      end
      run_frame(hxc, hyc);
      checks++;
      if (ball_x !== 9'd3 || hxc != 0) begin
         errors++;
         $display("FAIL x_tick44: x=%0d hit=%0d want 3 0", ball_x, hxc);
      end
   endtask

   task automatic test_pause();
      int hxc, hyc, tot;
      do_reset();
      do_launch(0, 0);
      for (int f = 0; f < 3; f++) begin
         run_frame(hxc, hyc);
         model_tick();
      end
      @(negedge clk);
      pause = 1'b1;
      tot = 0;
      for (int f = 0; f < 5; f++) begin
         run_frame(hxc, hyc);
         tot += hxc + hyc;
      end
      checks++;
      if (int'(ball_x) != mx || int'(ball_y) != my || tot != 0 || moving !== 1'b0) begin
         errors++;
         $display("FAIL pause_frozen: got (%0d,%0d) hits=%0d mv=%b want (%0d,%0d) 0 0",
                  ball_x, ball_y, tot, moving, mx, my);
      end
      @(negedge clk);
      pause = 1'b0;
      run_frame(hxc, hyc);
      model_tick();
      checks++;
      if (int'(ball_x) != mx || int'(ball_y) != my) begin
         errors++;
         $display("FAIL pause_resume: got (%0d,%0d) want (%0d,%0d)",
                  ball_x, ball_y, mx, my);
      end
   endtask

   task automatic test_reset_on_tick();
      int hxc, hyc;
      do_reset();
      do_launch(0, 0);
      for (int f = 0; f < 4; f++) run_frame(hxc, hyc);
      @(negedge clk);
      vsync = 1'b1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (ball_x !== 9'd128 || ball_y !== 9'd128 || hit_x !== 1'b0 ||
          hit_y !== 1'b0 || moving !== 1'b0) begin
         errors++;
         $display("FAIL reset_on_tick: (%0d,%0d) hx=%b hy=%b mv=%b want (128,128) 0 0 0",
                  ball_x, ball_y, hit_x, hit_y, moving);
      end
      @(negedge clk);
      reset = 1'b0;
      vsync = 1'b0;
   endtask

   task automatic test_gfx();
      int h, v, ei, eh, ev;
      do_reset();
      @(negedge clk);
      hpos = 9'd131; vpos = 9'd130;
      #1;
      checks++;
      if (ball_gfx !== 1'b1) begin
         errors++;
         $display("FAIL gfx_inside: got %b want 1", ball_gfx);
      end
      hpos = 9'd132;
      #1;
      checks++;
      if (ball_gfx !== 1'b0 || ball_hgfx !== 1'b0) begin
         errors++;
         $display("FAIL gfx_right: gfx=%b hgfx=%b want 0 0", ball_gfx, ball_hgfx);
      end
      hpos = 9'd127;
      #1;
      checks++;
      if (ball_hgfx !== 1'b0) begin
         errors++;
         $display("FAIL gfx_left: got %b want 0", ball_hgfx);
      end
      vpos = 9'd131;
      #1;
      checks++;
      if (ball_vgfx !== 1'b1) begin
         errors++;
         $display("FAIL gfx_bottom_row: got %b want 1", ball_vgfx);
      end
      for (int k = 0; k < 40; k++) begin
         h = 120 + int'($urandom_range(0, 15));
         v = (k % 2 == 0) ? int'($urandom_range(0, 511)) : 126 + int'($urandom_range(0, 7));
         hpos = 9'(h); vpos = 9'(v);
         #1;
         eh = (h >= 128 && h < 132) ? 1 : 0;
         ev = (v >= 128 && v < 132) ? 1 : 0;
         ei = eh & ev;
         checks++;
         if (int'(ball_hgfx) != eh || int'(ball_vgfx) != ev || int'(ball_gfx) != ei) begin
            errors++;
            $display("FAIL gfx_rand h=%0d v=%0d: got %b%b%b want %0d%0d%0d",
                     h, v, ball_hgfx, ball_vgfx, ball_gfx, eh, ev, ei);
         end
      end
   endtask

   task automatic test_random_motion();
      int hxc, hyc, paused;
      do_reset();
      do_launch(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
      for (int f = 0; f < 150; f++) begin
         paused = ($urandom_range(0, 4) == 0) ? 1 : 0;
         @(negedge clk);
         pause = paused[0];
         run_frame(hxc, hyc);
         if (paused == 0) model_tick();
         else begin mhx = 0; mhy = 0; end
         @(negedge clk);
         pause = 1'b0;
         checks++;
         if (int'(ball_x) != mx || int'(ball_y) != my || hxc != mhx || hyc != mhy) begin
            errors++;
            $display("FAIL rand_frame%0d: got (%0d,%0d) hits %0d/%0d want (%0d,%0d) %0d/%0d",
                     f, ball_x, ball_y, hxc, hyc, mx, my, mhx, mhy);
         end
      end
   endtask

   initial begin
      reset = 1'b1; vsync = 1'b0; launch = 1'b0; pause = 1'b0;
      hpos = '0; vpos = '0; dx_mag = '0; dy_mag = '0;
      test_reset();
      test_launch_default();
      test_y_bounce();
      test_x_bounce();
      test_pause();
      test_reset_on_tick();
      test_gfx();
      for (int r = 0; r < 4; r++) test_random_motion();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ball_bounce_engine.md
Name: ball_bounce_engine

Overview:
Parametrised bouncing-ball object for the video demos. Fully synchronous to the pixel clock: it detects frame boundaries from vsync and updates position once per frame. It clamps and bounces against programmable playfield bounds and reports wall hits as pulses. It also supplies launch/pause control and generates ball graphics from the beam position supplied by hvsync_generator.

Parameters:
WIDTH, 9, width of coordinates and beam position
BALL_SIZE, 4, ball edge length in pixels
X_MIN, 0, left bound (inclusive)
X_MAX, 256, right bound; ball_x never exceeds X_MAX-BALL_SIZE
Y_MIN, 0, top bound (inclusive)
Y_MAX, 240, bottom bound; ball_y never exceeds Y_MAX-BALL_SIZE
INIT_X, 128, reset/idle X position
INIT_Y, 128, reset/idle Y position
INIT_DX, -2, initial signed X velocity (pixels/frame)
INIT_DY, 2, initial signed Y velocity
SPEED_BITS, 4, width of launch speed magnitude inputs

Ports:
clk  in  1  pixel clock
reset  in  1  synchronous, active-high
vsync  in  1  vertical sync from hvsync_generator (clk domain)
hpos  in  WIDTH  beam X
vpos  in  WIDTH  beam Y
launch  in  1  start motion (level, sampled each clk)
pause  in  1  freeze motion while high
dx_mag  in  SPEED_BITS  X speed magnitude loaded on launch; 0 = use |INIT_DX|
dy_mag  in  SPEED_BITS  Y speed magnitude loaded on launch; 0 = use |INIT_DY|
ball_x  out  WIDTH  current X (registered)
ball_y  out  WIDTH  current Y (registered)
ball_hgfx  out  1  beam within ball columns
ball_vgfx  out  1  beam within ball rows
ball_gfx  out  1  beam inside ball
hit_x  out  1  one-clk pulse on left/right wall hit
hit_y  out  1  one-clk pulse on top/bottom wall hit
moving  out  1  high in RUN state

Behaviour:
- Reset (sync, overrides everything): state IDLE; ball_x=INIT_X, ball_y=INIT_Y; dx=INIT_DX, dy=INIT_DY; hit_x=hit_y=0; moving=0; vsync_q=0.
- frame_tick = vsync & ~vsync_q, where vsync_q is vsync registered; exactly one clk per vsync rising edge.
- States:
  - IDLE: position held at INIT. launch=1 loads |dx|=dx_mag (or |INIT_DX| if 0) with the sign of INIT_DX, and likewise for dy. Next state RUN.
  - RUN: pause=1 -> PAUSED. launch is ignored.
  - PAUSED: frame_ticks are ignored. pause=0 -> RUN.
  - Pause has priority over a same-cycle frame_tick.
- Update on frame_tick in RUN: compute nx = ball_x + dx and ny = ball_y + dy in signed WIDTH+2 bits, so no wrap.
  - dx<0 and nx <= X_MIN: ball_x=X_MIN, dx=+|dx|, hit_x=1.
  - dx>0 and nx >= X_MAX-BALL_SIZE: ball_x=X_MAX-BALL_SIZE, dx=-|dx|, hit_x=1.
  - Otherwise ball_x=nx, hit_x=0. The Y axis is identical with Y_MIN/Y_MAX and hit_y.
  - Exactly touching a bound counts as a hit. Both axes may hit in the same frame, giving both pulses in the same clk.
  - A zero-velocity axis never hits.
- Latency: position and hit pulses are registered one clk after the frame_tick cycle. hit_* are low on all other cycles.
- Positions change only at frame start, so graphics are stable across active video.
- Graphics (combinational from registered state):
  - hdiff = hpos - ball_x (mod 2^WIDTH); ball_hgfx = hdiff < BALL_SIZE.
  - vdiff = vpos - ball_y (mod 2^WIDTH); ball_vgfx = vdiff < BALL_SIZE.
  - ball_gfx = ball_hgfx & ball_vgfx. Beam left of or above the ball wraps large, so the output is 0.
- Legal parameters: X_MAX-BALL_SIZE > X_MIN + 2^SPEED_BITS, and the same for Y. INIT_DX and INIT_DY must be nonzero. Outside these ranges behaviour is undefined.

Test Plan:
- Reset, then 3 vsync pulses with launch=0 -> ball_x=128, ball_y=128, moving=0, no hit pulses.
- Launch with dx_mag=dy_mag=0 -> moving=1. After 1 tick: (126,130). After 10 ticks: (108,148).
- Launch dy_mag=2 -> on tick 54 ball_y=236 with one hit_y pulse. Tick 55: ball_y=234.
- Launch dx_mag=3 -> tick 42 ball_x=2. Tick 43: ball_x=0 with hit_x. Tick 44: ball_x=3.
- In RUN, hold pause through 5 vsyncs -> positions frozen, no hits. Release -> next tick moves by the velocity held before the pause. Assert reset coincident with a frame_tick -> IDLE at (128,128), hit_x=hit_y=0.
- Ball at (128,128): hpos=131, vpos=130 -> ball_gfx=1. hpos=132 -> 0. hpos=127 -> ball_hgfx=0. vpos=131 -> ball_vgfx=1.
